// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

  // Control-flow operation codes presented by execute.
  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLT  = 4'd3;
  localparam logic [3:0] BR_BGE  = 4'd4;
  localparam logic [3:0] BR_BLTU = 4'd5;
  localparam logic [3:0] BR_BGEU = 4'd6;
  localparam logic [3:0] BR_JAL  = 4'd7;
  localparam logic [3:0] BR_JALR = 4'd8;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered fetch result.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Branch condition from the ALU compare flags; unknown codes never take.
  function automatic logic br_cond(input logic [3:0] op, input logic zero,
                                   input logic lt, input logic ltu);
    logic c;
    case (op)
      BR_BEQ:  c = zero;
      BR_BNE:  c = ~zero;
      BR_BLT:  c = lt;
      BR_BGE:  c = ~lt;
      BR_BLTU: c = ltu;
      BR_BGEU: c = ~ltu;
      BR_JAL:  c = 1'b1;
      BR_JALR: c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Circular prefetch buffer of {pc, inst} entries. Clear wins over push/pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int CW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (CW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // Head is forced to zero when empty so stale data never shows.
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (CW+1)'(do_push) - (CW+1)'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC generation, ROM issue, prefetch buffering and
// control-flow redirect resolution.
//
// Decode handshake: an entry transfers on a rising edge where inst_valid and
// inst_ready are both high; while inst_valid is high and inst_ready low the
// head (inst, inst_pc) does not change unless a redirect flushes the buffer.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               IMEM_AW  = 14,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [XLEN-1:0]     inst,
  output logic [XLEN-1:0]     inst_pc,
  input  logic                ex_valid,
  input  logic [3:0]          ex_br_op,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic [XLEN-1:0]     ex_imm,
  input  logic [XLEN-1:0]     ex_rs1,
  input  logic                ex_zero,
  input  logic                ex_lt,
  input  logic                ex_ltu,
  output logic                redirect,
  output logic                misalign,
  output logic [XLEN-1:0]     misalign_addr
);

  localparam int CW = $clog2(DEPTH);
  localparam int OW = CW + 2;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic            inflight_q, inflight_d;
  logic            drop_q, drop_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] target;
  logic            taken, aligned, redir_now, mis_now;
  logic            pop, push, discard, issue;
  logic [OW-1:0]   occ;
  logic [CW:0]     count;
  logic            full, empty;
  fetch_entry_t    wr_entry, head;

  // Resolve the execute-stage op: target, taken and alignment.
  always_comb begin
    if (ex_br_op == BR_JALR) begin
      target    = ex_rs1 + ex_imm;
      target[0] = 1'b0;
    end else begin
      target = ex_pc + ex_imm;
    end
    taken     = ex_valid & br_cond(ex_br_op, ex_zero, ex_lt, ex_ltu);
    aligned   = (target[1:0] == 2'b00);
    redir_now = taken & aligned;
    mis_now   = taken & ~aligned;
  end

  // Issue gating and buffer write. Occupancy counts the in-flight response
  // so the buffer can never overflow; a redirect beats both pop and push.
  always_comb begin
    pop      = ~empty & inst_ready;
    occ      = OW'(count) + OW'(inflight_q) - OW'(pop);
    issue    = ~redir_now & (occ < OW'(DEPTH));
    discard  = drop_q | redir_now;
    push     = inflight_q & ~discard & (~full | pop);
    wr_entry = '{pc: inflight_pc_q, inst: imem_rdata};
  end

  // Next-state for PC, in-flight tracking and the registered pulses.
  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    inflight_pc_d   = inflight_pc_q;
    misalign_addr_d = misalign_addr_q;
    drop_d          = drop_q;
    if (redir_now)  fetch_pc_d = target;
    else if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
    inflight_d = issue;
    if (issue) inflight_pc_d = fetch_pc_q;
    // The response landing this cycle is consumed or discarded here.
    if (inflight_q) drop_d = 1'b0;
    // Issue is held off on a redirect today; the flag still guarantees a
    // request racing a redirect can never reach the buffer.
    if (redir_now && issue) drop_d = 1'b1;
    redirect_d = redir_now;
    misalign_d = mis_now;
    if (mis_now) misalign_addr_d = target;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q      <= RESET_PC;
      inflight_pc_q   <= '0;
      misalign_addr_q <= '0;
      inflight_q      <= 1'b0;
      drop_q          <= 1'b0;
      redirect_q      <= 1'b0;
      misalign_q      <= 1'b0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inflight_pc_q   <= inflight_pc_d;
      misalign_addr_q <= misalign_addr_d;
      inflight_q      <= inflight_d;
      drop_q          <= drop_d;
      redirect_q      <= redirect_d;
      misalign_q      <= misalign_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redir_now),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign imem_en       = issue;
  assign imem_addr     = fetch_pc_q[IMEM_AW+1:2];
  assign inst_valid    = ~empty;
  assign inst          = head.inst;
  assign inst_pc       = head.pc;
  assign redirect      = redirect_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule
